clk_en_gen: RTL and testbench

CLK_EN_GEN -- requirements
Module: clk_en_gen

---
 rtl/clk_en_gen_pkg.sv | 14 +
 rtl/clk_en_gen_sync_2ff.sv | 22 ++
 rtl/clk_en_gen.sv | 120 ++++++++++++
 tb/tb_clk_en_gen.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/clk_en_gen_pkg.sv
// Shared definitions for the clock-enable generator: FSM state type and
// default parameter values.
package clk_en_gen_pkg;

    localparam int LOCK_STABLE_CYCLES_DEF = 1024;
    localparam int DIV_DEF                = 5;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'b00,
        STABLE    = 2'b01,
        RUN       = 2'b10
    } state_t;

endpackage

// File: rtl/clk_en_gen_sync_2ff.sv
// Two-flop synchroniser bringing an asynchronous level into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Double-register the asynchronous input; both flops clear on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/clk_en_gen.sv
// Clock-enable generator: waits for a stable PLL lock, releases the core
// reset, then emits clk28_en every DIV cycles plus the quarter-rate
// clk7_en / clk7n_en enables on opposite phases.
// Optional macro CLK_EN_GEN_RELOCK_RESET_EN: loss of lock while running
// returns to WAIT_LOCK and re-asserts the core reset. Without it the
// running state is held until rst_n.
module clk_en_gen
    import clk_en_gen_pkg::*;
#(
    parameter int LOCK_STABLE_CYCLES = LOCK_STABLE_CYCLES_DEF,
    parameter int DIV                = DIV_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pll_lock,
    output logic sys_rst_n,
    output logic clk28_en,
    output logic clk7_en,
    output logic clk7n_en,
    output logic locked
);

    localparam logic [15:0] STABLE_LAST = 16'(LOCK_STABLE_CYCLES - 1);
    localparam logic [3:0]  DIV_LAST    = 4'(DIV - 1);

    logic        lock_s;
    state_t      state;
    state_t      next_state;
    logic [15:0] stable_cnt;
    logic        run_q;
    logic        state_run;
    logic [3:0]  cnt;
    logic [1:0]  phase;

    sync_2ff u_sync_lock (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

    assign state_run = (state == RUN);

    // Lock supervision: require an unbroken run of synchronised lock.
    always_comb begin
        next_state = state;
        unique case (state)
            WAIT_LOCK: begin
                if (lock_s) next_state = STABLE;
            end
            STABLE: begin
                if (!lock_s)                        next_state = WAIT_LOCK;
                else if (stable_cnt == STABLE_LAST) next_state = RUN;
            end
            RUN: begin
`ifdef CLK_EN_GEN_RELOCK_RESET_EN
                if (!lock_s) next_state = WAIT_LOCK;
`else
                next_state = RUN;
`endif
            end
            default: next_state = WAIT_LOCK;
        endcase
    end

    // State register and stable counter; counter restarts on every STABLE entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= WAIT_LOCK;
            stable_cnt <= '0;
        end else begin
            state <= next_state;
            if (state == STABLE && next_state == STABLE)
                stable_cnt <= stable_cnt + 16'd1;
            else
                stable_cnt <= '0;
        end
    end

    // Core reset and lock flag follow RUN one cycle later, glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run_q <= 1'b0;
        else        run_q <= state_run;
    end

    assign sys_rst_n = run_q;
    assign locked    = run_q;

    // Divider and phase: counts only while reset is released and still in
    // RUN, so no enable can coincide with sys_rst_n low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            phase    <= '0;
            clk28_en <= 1'b0;
            clk7_en  <= 1'b0;
            clk7n_en <= 1'b0;
        end else if (run_q && state_run) begin
            if (cnt == DIV_LAST) begin
                cnt      <= '0;
                phase    <= phase + 2'd1;
                clk28_en <= 1'b1;
                clk7_en  <= (phase == 2'd3);
                clk7n_en <= (phase == 2'd1);
            end else begin
                cnt      <= cnt + 4'd1;
                clk28_en <= 1'b0;
                clk7_en  <= 1'b0;
                clk7n_en <= 1'b0;
            end
        end else begin
            cnt      <= '0;
            phase    <= '0;
            clk28_en <= 1'b0;
            clk7_en  <= 1'b0;
            clk7n_en <= 1'b0;
        end
    end

endmodule

// File: tb/tb_clk_en_gen.sv
// Directed bench for clk_en_gen with LOCK_STABLE_CYCLES=16, DIV=5.
module tb_clk_en_gen;

    localparam int L = 16;
    localparam int D = 5;

    logic clk = 1'b0;
    logic rst_n;
    logic pll_lock;
    logic sys_rst_n;
    logic clk28_en;
    logic clk7_en;
    logic clk7n_en;
    logic locked;

    int n_cmp = 0;
    int n_err = 0;

    clk_en_gen #(.LOCK_STABLE_CYCLES(L), .DIV(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pll_lock  (pll_lock),
        .sys_rst_n (sys_rst_n),
        .clk28_en  (clk28_en),
        .clk7_en   (clk7_en),
        .clk7n_en  (clk7n_en),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    // Expected enable pattern, b = edge of the first clk28_en pulse.
    function automatic logic exp28(int e, int b);
        if (e < b) return 1'b0;
        return ((e - b) % D) == 0;
    endfunction

    function automatic logic exp7(int e, int b);
        if (e < b) return 1'b0;
        return ((e - b) % (4 * D)) == 3 * D;
    endfunction

    function automatic logic exp7n(int e, int b);
        if (e < b) return 1'b0;
        return ((e - b) % (4 * D)) == D;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset, release it mid-cycle; the next posedge is edge 0.
    task automatic start_from_reset();
        rst_n    = 1'b0;
        pll_lock = 1'b0;
        #7;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        pll_lock = 1'b1;
        repeat (4) tick();
        n_cmp++; if (sys_rst_n !== 1'b0) begin n_err++; $display("FAIL reset_sys_rst_n got %b want 0", sys_rst_n); end
        n_cmp++; if (locked !== 1'b0)    begin n_err++; $display("FAIL reset_locked got %b want 0", locked); end
        n_cmp++; if (clk28_en !== 1'b0)  begin n_err++; $display("FAIL reset_clk28_en got %b want 0", clk28_en); end
        n_cmp++; if (clk7_en !== 1'b0)   begin n_err++; $display("FAIL reset_clk7_en got %b want 0", clk7_en); end
        n_cmp++; if (clk7n_en !== 1'b0)  begin n_err++; $display("FAIL reset_clk7n_en got %b want 0", clk7n_en); end
    endtask

    // Lock from edge 0: reset release at edge 19, first clk28_en at 24,
    // then 200 cycles of steady enables.
    task automatic test_lock_and_run();
        start_from_reset();
        pll_lock = 1'b1;
        for (int e = 0; e < 230; e++) begin
            tick();
            n_cmp++; if (sys_rst_n !== (e >= 19)) begin n_err++; $display("FAIL seq_sys_rst_n e=%0d got %b want %b", e, sys_rst_n, (e >= 19)); end
            n_cmp++; if (locked !== (e >= 19))    begin n_err++; $display("FAIL seq_locked e=%0d got %b want %b", e, locked, (e >= 19)); end
            n_cmp++; if (clk28_en !== exp28(e, 24)) begin n_err++; $display("FAIL run_clk28_en e=%0d got %b want %b", e, clk28_en, exp28(e, 24)); end
            n_cmp++; if (clk7_en !== exp7(e, 24))   begin n_err++; $display("FAIL run_clk7_en e=%0d got %b want %b", e, clk7_en, exp7(e, 24)); end
            n_cmp++; if (clk7n_en !== exp7n(e, 24)) begin n_err++; $display("FAIL run_clk7n_en e=%0d got %b want %b", e, clk7n_en, exp7n(e, 24)); end
            n_cmp++; if ((clk7_en & clk7n_en) !== 1'b0) begin n_err++; $display("FAIL run_coincident e=%0d got %b want 0", e, clk7_en & clk7n_en); end
        end
    endtask

    // One sampled low at edge 10 restarts the count: release at edge 30,
    // then lock drop sampled from edge 40 while running.
    task automatic test_glitch_and_drop();
        start_from_reset();
        for (int e = 0; e < 76; e++) begin
            pll_lock = (e == 10 || e >= 40) ? 1'b0 : 1'b1;
            tick();
            if (e < 36) begin
                n_cmp++; if (sys_rst_n !== (e >= 30)) begin n_err++; $display("FAIL glitch_sys_rst_n e=%0d got %b want %b", e, sys_rst_n, (e >= 30)); end
            end else begin
`ifdef CLK_EN_GEN_RELOCK_RESET_EN
                n_cmp++; if (sys_rst_n !== (e < 43)) begin n_err++; $display("FAIL drop_sys_rst_n e=%0d got %b want %b", e, sys_rst_n, (e < 43)); end
                n_cmp++; if (clk28_en !== (exp28(e, 35) && e < 43)) begin n_err++; $display("FAIL drop_clk28_en e=%0d got %b want %b", e, clk28_en, (exp28(e, 35) && e < 43)); end
                n_cmp++; if ((clk7_en | clk7n_en) !== ((exp7(e, 35) | exp7n(e, 35)) && e < 43)) begin n_err++; $display("FAIL drop_clk7 e=%0d got %b want %b", e, clk7_en | clk7n_en, ((exp7(e, 35) | exp7n(e, 35)) && e < 43)); end
`else
                n_cmp++; if (sys_rst_n !== 1'b1) begin n_err++; $display("FAIL drop_sys_rst_n e=%0d got %b want 1", e, sys_rst_n); end
                n_cmp++; if (clk28_en !== exp28(e, 35)) begin n_err++; $display("FAIL drop_clk28_en e=%0d got %b want %b", e, clk28_en, exp28(e, 35)); end
                n_cmp++; if (clk7_en !== exp7(e, 35))   begin n_err++; $display("FAIL drop_clk7_en e=%0d got %b want %b", e, clk7_en, exp7(e, 35)); end
                n_cmp++; if (clk7n_en !== exp7n(e, 35)) begin n_err++; $display("FAIL drop_clk7n_en e=%0d got %b want %b", e, clk7n_en, exp7n(e, 35)); end
`endif
            end
        end
    endtask

    // rst_n pulsed mid-RUN: immediate drop, then full sequence from cnt=0, phase=0.
    task automatic test_async_reset();
        start_from_reset();
        pll_lock = 1'b1;
        repeat (41) tick();
        n_cmp++; if (sys_rst_n !== 1'b1) begin n_err++; $display("FAIL pre_async_sys_rst_n got %b want 1", sys_rst_n); end
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (sys_rst_n !== 1'b0) begin n_err++; $display("FAIL async_sys_rst_n got %b want 0", sys_rst_n); end
        n_cmp++; if (locked !== 1'b0)    begin n_err++; $display("FAIL async_locked got %b want 0", locked); end
        n_cmp++; if ((clk28_en | clk7_en | clk7n_en) !== 1'b0) begin n_err++; $display("FAIL async_enables got %b want 0", clk28_en | clk7_en | clk7n_en); end
        #2;
        rst_n = 1'b1;
        for (int e = 0; e < 50; e++) begin
            tick();
            n_cmp++; if (sys_rst_n !== (e >= 19))   begin n_err++; $display("FAIL rerun_sys_rst_n e=%0d got %b want %b", e, sys_rst_n, (e >= 19)); end
            n_cmp++; if (clk28_en !== exp28(e, 24)) begin n_err++; $display("FAIL rerun_clk28_en e=%0d got %b want %b", e, clk28_en, exp28(e, 24)); end
            n_cmp++; if (clk7_en !== exp7(e, 24))   begin n_err++; $display("FAIL rerun_clk7_en e=%0d got %b want %b", e, clk7_en, exp7(e, 24)); end
            n_cmp++; if (clk7n_en !== exp7n(e, 24)) begin n_err++; $display("FAIL rerun_clk7n_en e=%0d got %b want %b", e, clk7n_en, exp7n(e, 24)); end
        end
    endtask

    initial begin
        test_reset();
        test_lock_and_run();
        test_glitch_and_drop();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
